// File: rtl/stoch_sop_pkg.sv
// Shared types and defaults for the stochastic sum-of-products accumulator.
package stoch_sop_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } sop_state_t;

  localparam int unsigned SOP_N_PAIRS = 4;
  localparam int unsigned SOP_WIN_LEN = 256;

  // Counter width able to hold 0..win_len inclusive.
  function automatic int unsigned cnt_width(input int unsigned win_len);
    return $clog2(win_len + 1);
  endfunction

endpackage

// File: rtl/sop_bit_core.sv
// Combinational AND-OR reduction over N_PAIRS bitstream pairs.
// STOCH_SOP_MASK_EN adds a per-pair enable mask.
module sop_bit_core #(
  parameter int unsigned N_PAIRS = 4
) (
  input  logic [N_PAIRS-1:0] a_bits,
  input  logic [N_PAIRS-1:0] b_bits,
`ifdef STOCH_SOP_MASK_EN
  input  logic [N_PAIRS-1:0] pair_mask,
`endif
  output logic               p_c
);

  // Unipolar multiply per pair, approximate add across pairs.
  always_comb begin
`ifdef STOCH_SOP_MASK_EN
    p_c = |(a_bits & b_bits & pair_mask);
`else
    p_c = |(a_bits & b_bits);
`endif
  end

endmodule

// File: rtl/stoch_sop_accum.sv
// Stochastic sum-of-products unit: OR-of-ANDs per sample, ones counted over a
// WIN_LEN-sample window, result delivered on a valid/ready handshake.
// Optional feature: STOCH_SOP_MASK_EN adds the pair_mask input.
module stoch_sop_accum
  import stoch_sop_pkg::*;
#(
  parameter int unsigned N_PAIRS = SOP_N_PAIRS,
  parameter int unsigned WIN_LEN = SOP_WIN_LEN,
  parameter int unsigned CNT_W   = cnt_width(WIN_LEN)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               bit_valid,
  input  logic [N_PAIRS-1:0] a_bits,
  input  logic [N_PAIRS-1:0] b_bits,
`ifdef STOCH_SOP_MASK_EN
  input  logic [N_PAIRS-1:0] pair_mask,
`endif
  output logic               y_bit,
  output logic               y_valid,
  output logic               busy,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [CNT_W-1:0]   res_count
);

  localparam int unsigned SAMP_W = $clog2(WIN_LEN);
  localparam logic [SAMP_W-1:0] LAST_SAMP = SAMP_W'(WIN_LEN - 1);

  sop_state_t        state;
  logic [SAMP_W-1:0] samp_cnt;
  logic [CNT_W-1:0]  ones_cnt;
  logic              p_c;

  sop_bit_core #(
    .N_PAIRS (N_PAIRS)
  ) u_core (
    .a_bits    (a_bits),
    .b_bits    (b_bits),
`ifdef STOCH_SOP_MASK_EN
    .pair_mask (pair_mask),
`endif
    .p_c       (p_c)
  );

  // Product stream register, window FSM, counters and result handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      y_bit     <= 1'b0;
      y_valid   <= 1'b0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_count <= '0;
      samp_cnt  <= '0;
      ones_cnt  <= '0;
    end else begin
      y_bit   <= p_c;
      y_valid <= bit_valid;
      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            samp_cnt <= '0;
            ones_cnt <= '0;
          end
        end
        RUN: begin
          if (bit_valid) begin
            if (samp_cnt == LAST_SAMP) begin
              // Final sample folds straight into the result; counters rearm.
              res_count <= ones_cnt + CNT_W'(p_c);
              res_valid <= 1'b1;
              busy      <= 1'b0;
              state     <= HOLD;
              samp_cnt  <= '0;
              ones_cnt  <= '0;
            end else begin
              samp_cnt <= samp_cnt + SAMP_W'(1);
              ones_cnt <= ones_cnt + CNT_W'(p_c);
            end
          end
        end
        HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            samp_cnt  <= '0;
            ones_cnt  <= '0;
            if (start) begin
              state <= RUN;
              busy  <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          res_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_sop_accum.sv
// Self-checking bench for stoch_sop_accum (N_PAIRS=4, WIN_LEN=8).
// Honours STOCH_SOP_MASK_EN when the design is built with it.
module tb_stoch_sop_accum;

  localparam int unsigned NP    = 4;
  localparam int unsigned WL    = 8;
  localparam int unsigned CW    = $clog2(WL + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          bit_valid = 1'b0;
  logic [NP-1:0] a_bits = '0;
  logic [NP-1:0] b_bits = '0;
  logic [NP-1:0] pair_mask = '1;
  logic          res_ready = 1'b0;
  logic          y_bit, y_valid, busy, res_valid;
  logic [CW-1:0] res_count;

  stoch_sop_accum #(
    .N_PAIRS (NP),
    .WIN_LEN (WL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bits    (a_bits),
    .b_bits    (b_bits),
`ifdef STOCH_SOP_MASK_EN
    .pair_mask (pair_mask),
`endif
    .y_bit     (y_bit),
    .y_valid   (y_valid),
    .busy      (busy),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_count (res_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: window membership plus the list of products seen so far.
  bit in_win     = 1'b0;
  bit have_res   = 1'b0;
  int exp_res    = 0;
  bit exp_yb     = 1'b0;
  bit exp_yv     = 1'b0;
  bit win_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit prod(input logic [NP-1:0] a, input logic [NP-1:0] b,
                              input logic [NP-1:0] m);
    bit r = 1'b0;
    for (int i = 0; i < NP; i++) begin
`ifdef STOCH_SOP_MASK_EN
      if (a[i] && b[i] && m[i]) r = 1'b1;
`else
      if (a[i] && b[i]) r = 1'b1;
`endif
    end
    return r;
  endfunction

  task automatic model_reset();
    in_win   = 1'b0;
    have_res = 1'b0;
    exp_res  = 0;
    exp_yb   = 1'b0;
    exp_yv   = 1'b0;
    win_q.delete();
  endtask

  // Apply one cycle of inputs, advance the model, compare all outputs.
  task automatic tick(input bit st, input bit bv, input logic [NP-1:0] a,
                      input logic [NP-1:0] b, input logic [NP-1:0] m, input bit rr);
    bit p;
    int sum;
    start = st; bit_valid = bv; a_bits = a; b_bits = b; pair_mask = m; res_ready = rr;
    p = prod(a, b, m);
    @(posedge clk);
    #1;
    exp_yb = p;
    exp_yv = bv;
    if (have_res) begin
      if (rr) begin
        have_res = 1'b0;
        if (st) begin
          in_win = 1'b1;
          win_q.delete();
        end
      end
    end else if (in_win) begin
      if (bv) begin
        win_q.push_back(p);
        if (win_q.size() == WL) begin
          sum = 0;
          foreach (win_q[i]) sum += int'(win_q[i]);
          exp_res  = sum;
          have_res = 1'b1;
          in_win   = 1'b0;
          win_q.delete();
        end
      end
    end else if (st) begin
      in_win = 1'b1;
      win_q.delete();
    end
    chk("y_valid",   int'(y_valid),   int'(exp_yv));
    chk("y_bit",     int'(y_bit),     int'(exp_yb));
    chk("busy",      int'(busy),      int'(in_win));
    chk("res_valid", int'(res_valid), int'(have_res));
    chk("res_count", int'(res_count), exp_res);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_y_bit"},     int'(y_bit),     0);
    chk({tag, "_y_valid"},   int'(y_valid),   0);
    chk({tag, "_busy"},      int'(busy),      0);
    chk({tag, "_res_valid"}, int'(res_valid), 0);
    chk({tag, "_res_count"}, int'(res_count), 0);
  endtask

  typedef struct {
    logic [NP-1:0] a;
    logic [NP-1:0] b;
    logic [NP-1:0] m;
    int            exp_count;
    bit            exp_ybit;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{a: 4'b0001, b: 4'b0001, m: 4'b1111, exp_count: 8, exp_ybit: 1'b1});
    vecs.push_back('{a: 4'b1010, b: 4'b0101, m: 4'b1111, exp_count: 0, exp_ybit: 1'b0});
    vecs.push_back('{a: 4'b1111, b: 4'b0000, m: 4'b1111, exp_count: 0, exp_ybit: 1'b0});
    vecs.push_back('{a: 4'b0110, b: 4'b0100, m: 4'b1111, exp_count: 8, exp_ybit: 1'b1});
    vecs.push_back('{a: 4'b1111, b: 4'b1111, m: 4'b1111, exp_count: 8, exp_ybit: 1'b1});
`ifdef STOCH_SOP_MASK_EN
    vecs.push_back('{a: 4'b0001, b: 4'b0001, m: 4'b1110, exp_count: 0, exp_ybit: 1'b0});
    vecs.push_back('{a: 4'b0001, b: 4'b0001, m: 4'b1111, exp_count: 8, exp_ybit: 1'b1});
    vecs.push_back('{a: 4'b1001, b: 4'b1001, m: 4'b1000, exp_count: 8, exp_ybit: 1'b1});
`endif

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    model_reset();

    // Constant-input full windows from the table.
    foreach (vecs[k]) begin
      tick(1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0);
      for (int s = 0; s < WL; s++) tick(1'b0, 1'b1, vecs[k].a, vecs[k].b, vecs[k].m, 1'b0);
      chk("tbl_res_valid", int'(res_valid), 1);
      chk("tbl_res_count", int'(res_count), vecs[k].exp_count);
      chk("tbl_busy",      int'(busy),      0);
      chk("tbl_y_bit",     int'(y_bit),     int'(vecs[k].exp_ybit));
      tick(1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b1);
      chk("tbl_release",   int'(res_valid), 0);
    end

    // bit_valid toggling stalls the window: 8 samples over 16 cycles.
    tick(1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0);
    for (int s = 0; s < 2 * WL; s++) begin
      if (s == 2 * WL - 2) chk("tog_not_yet", int'(res_valid), 0);
      tick(1'b0, (s % 2) == 0, 4'hF, 4'hF, 4'hF, 1'b0);
    end
    chk("tog_res_valid", int'(res_valid), 1);
    chk("tog_res_count", int'(res_count), 8);

    // HOLD with res_ready low: start ignored, result stable.
    for (int s = 0; s < 5; s++) begin
      tick(s[0], 1'b1, 4'h0, 4'h0, 4'hF, 1'b0);
      chk("hold_count", int'(res_count), 8);
      chk("hold_valid", int'(res_valid), 1);
      chk("hold_busy",  int'(busy), 0);
    end
    // Accept and restart in the same cycle.
    tick(1'b1, 1'b1, 4'hF, 4'hF, 4'hF, 1'b1);
    chk("b2b_res_valid", int'(res_valid), 0);
    chk("b2b_busy",      int'(busy), 1);
    for (int s = 0; s < WL; s++) tick(1'b0, 1'b1, 4'b0011, 4'b0010, 4'hF, 1'b0);
    chk("b2b_count", int'(res_count), 8);
    tick(1'b0, 1'b0, 4'h0, 4'h0, 4'hF, 1'b1);

    // Reset mid-window discards the partial count.
    tick(1'b1, 1'b0, 4'h0, 4'h0, 4'hF, 1'b0);
    for (int s = 0; s < 4; s++) tick(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int s = 0; s < WL + 2; s++) tick(1'b0, 1'b1, 4'hF, 4'hF, 4'hF, 1'b0);
    chk("midrst_no_res", int'(res_valid), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick(($urandom % 6) == 0, ($urandom % 4) != 0,
           NP'($urandom), NP'($urandom),
`ifdef STOCH_SOP_MASK_EN
           NP'($urandom),
`else
           4'hF,
`endif
           ($urandom % 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
